// File: rtl/reuse_module_pkg.sv
// Shared defaults for the row-reuse delay block.
package reuse_module_pkg;

    localparam int unsigned BIT_WIDTH_DEF = 8;
    localparam int unsigned BUF_WIDTH_DEF = 9;
    localparam int unsigned BUF_SIZE_DEF  = 257;
    localparam int unsigned COL_DEF       = 8;

endpackage

// File: rtl/reuse_line.sv
// Single-channel circular row-delay array with a registered, masked output.
// Optional macro REUSE_CLEAR_EN: reset also clears every storage entry.
module reuse_line
    import reuse_module_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int unsigned BUF_WIDTH = BUF_WIDTH_DEF,
    parameter int unsigned BUF_SIZE  = BUF_SIZE_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [BUF_WIDTH-1:0] wr_idx,
    input  logic [BUF_WIDTH-1:0] rd_idx,
    input  logic                 valid,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
);

    logic [BIT_WIDTH-1:0] mem [BUF_SIZE];

`ifdef REUSE_CLEAR_EN
    // Storage write; reset wipes the whole array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BUF_SIZE); i++) begin
                mem[i] <= '0;
            end
        end else if (en) begin
            mem[wr_idx] <= din;
        end
    end
`else
    // Storage write; contents are never reset, the fill mask hides stale data.
    always_ff @(posedge clk) begin
        if (rst_n && en) begin
            mem[wr_idx] <= din;
        end
    end
`endif

    // Output register: oldest sample, or the incoming one when the row is one deep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (en) begin
            if (!valid) begin
                dout <= '0;
            end else if (rd_idx == wr_idx) begin
                dout <= din;
            end else begin
                dout <= mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/reuse_module.sv
// Two-channel row delay: both channels share one write pointer and fill counter.
// Optional macro REUSE_CLEAR_EN: reset also clears storage (outputs identical either way).
module reuse_module
    import reuse_module_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = BIT_WIDTH_DEF,
    parameter int unsigned BUF_WIDTH = BUF_WIDTH_DEF,
    parameter int unsigned BUF_SIZE  = BUF_SIZE_DEF,
    parameter int unsigned COL       = COL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [BUF_WIDTH-1:0] col,
    input  logic [BIT_WIDTH-1:0] buf_in1,
    input  logic [BIT_WIDTH-1:0] buf_in2,
    output logic [BIT_WIDTH-1:0] buf_out1,
    output logic [BIT_WIDTH-1:0] buf_out2
);

    localparam int unsigned LEN_MAX = BUF_SIZE - 1;

    logic [BUF_WIDTH-1:0] wr_ptr;
    logic [BUF_WIDTH-1:0] fill;
    logic [BUF_WIDTH-1:0] col_q;

    logic [BUF_WIDTH-1:0] len_c;
    logic [BUF_WIDTH-1:0] last_c;
    logic                 col_chg_c;
    logic [BUF_WIDTH-1:0] ptr_cur_c;
    logic [BUF_WIDTH-1:0] fill_cur_c;
    logic [BUF_WIDTH-1:0] ptr_nxt_c;
    logic [BUF_WIDTH-1:0] fill_nxt_c;
    logic                 valid_c;

    // Clamp row length, restart on a col change, derive next pointer/fill and read slot.
    always_comb begin
        len_c      = col;
        last_c     = '0;
        col_chg_c  = 1'b0;
        ptr_cur_c  = wr_ptr;
        fill_cur_c = fill;
        ptr_nxt_c  = '0;
        fill_nxt_c = '0;
        valid_c    = 1'b0;

        if (col == '0) begin
            len_c = BUF_WIDTH'(1);
        end else if (col > BUF_WIDTH'(LEN_MAX)) begin
            len_c = BUF_WIDTH'(LEN_MAX);
        end
        last_c = len_c - BUF_WIDTH'(1);

        // A new col restarts the row at this very edge (this edge is the first capture).
        col_chg_c = (col != col_q);
        if (col_chg_c) begin
            ptr_cur_c  = '0;
            fill_cur_c = '0;
        end

        // Next write slot is also the oldest live sample.
        ptr_nxt_c  = (ptr_cur_c == last_c) ? '0 : ptr_cur_c + BUF_WIDTH'(1);
        fill_nxt_c = (fill_cur_c >= len_c) ? len_c : fill_cur_c + BUF_WIDTH'(1);
        valid_c    = (fill_cur_c >= last_c);
    end

    // Shared pointer, fill counter and col tracking; frozen while en is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            fill   <= '0;
            col_q  <= BUF_WIDTH'(COL);
        end else if (en) begin
            wr_ptr <= ptr_nxt_c;
            fill   <= fill_nxt_c;
            col_q  <= col;
        end
    end

    reuse_line #(
        .BIT_WIDTH (BIT_WIDTH),
        .BUF_WIDTH (BUF_WIDTH),
        .BUF_SIZE  (BUF_SIZE)
    ) u_line1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .wr_idx (ptr_cur_c),
        .rd_idx (ptr_nxt_c),
        .valid  (valid_c),
        .din    (buf_in1),
        .dout   (buf_out1)
    );

    reuse_line #(
        .BIT_WIDTH (BIT_WIDTH),
        .BUF_WIDTH (BUF_WIDTH),
        .BUF_SIZE  (BUF_SIZE)
    ) u_line2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .wr_idx (ptr_cur_c),
        .rd_idx (ptr_nxt_c),
        .valid  (valid_c),
        .din    (buf_in2),
        .dout   (buf_out2)
    );

endmodule

// File: tb/tb_reuse_module.sv
// Scoreboard bench for reuse_module: queue-based history model vs. DUT outputs.
module tb_reuse_module;
    import reuse_module_pkg::*;

    localparam int unsigned BW   = BIT_WIDTH_DEF;
    localparam int unsigned UW   = BUF_WIDTH_DEF;
    localparam int unsigned BS   = BUF_SIZE_DEF;
    localparam int unsigned COLN = COL_DEF;
    localparam int unsigned LMAX = BS - 1;

    typedef struct packed {
        logic [BW-1:0] o1;
        logic [BW-1:0] o2;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [UW-1:0] col;
    logic [BW-1:0] buf_in1;
    logic [BW-1:0] buf_in2;
    logic [BW-1:0] buf_out1;
    logic [BW-1:0] buf_out2;

    exp_t          exp_q[$];
    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;

    // Reference model state: samples captured since the last restart.
    logic [BW-1:0] h1[$];
    logic [BW-1:0] h2[$];
    logic [UW-1:0] m_prev;
    exp_t          m_out;

    always #5 clk = ~clk;

    reuse_module dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .col      (col),
        .buf_in1  (buf_in1),
        .buf_in2  (buf_in2),
        .buf_out1 (buf_out1),
        .buf_out2 (buf_out2)
    );

    function automatic int eff_len(input logic [UW-1:0] c);
        if (c == '0) return 1;
        if (int'(c) > int'(LMAX)) return int'(LMAX);
        return int'(c);
    endfunction

    // One rising edge of the reference behaviour.
    function void model_edge(input logic r, input logic e, input logic [UW-1:0] c,
                             input logic [BW-1:0] a, input logic [BW-1:0] b);
        int len;
        if (!r) begin
            h1.delete();
            h2.delete();
            m_prev = UW'(COLN);
            m_out  = '0;
        end else if (e) begin
            len = eff_len(c);
            if (c != m_prev) begin
                h1.delete();
                h2.delete();
            end
            m_prev = c;
            h1.push_back(a);
            h2.push_back(b);
            if (h1.size() > int'(LMAX)) begin
                void'(h1.pop_front());
                void'(h2.pop_front());
            end
            if (h1.size() >= len) begin
                m_out.o1 = h1[h1.size() - len];
                m_out.o2 = h2[h2.size() - len];
            end else begin
                m_out = '0;
            end
        end
    endfunction

    // Drive one cycle of stimulus and queue the expected post-edge outputs.
    task automatic drive(input logic r, input logic e, input logic [UW-1:0] c,
                         input logic [BW-1:0] a, input logic [BW-1:0] b);
        @(negedge clk);
        rst_n   = r;
        en      = e;
        col     = c;
        buf_in1 = a;
        buf_in2 = b;
        model_edge(r, e, c, a, b);
        exp_q.push_back(m_out);
    endtask

    // Monitor: compare outputs just after every edge that has an expectation.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (exp_q.size() != 0) begin
            exp_t x;
            x = exp_q.pop_front();
            n_checks++;
            if (buf_out1 === x.o1) n_pass++;
            else $display("FAIL buf_out1 cyc=%0d got=%0d exp=%0d", cyc, buf_out1, x.o1);
            n_checks++;
            if (buf_out2 === x.o2) n_pass++;
            else $display("FAIL buf_out2 cyc=%0d got=%0d exp=%0d", cyc, buf_out2, x.o2);
        end
    end

    initial begin
        logic [UW-1:0] col_tab [13];
        logic [UW-1:0] cur_col;
        int            k;
        logic          r;
        logic          e;
        logic [BW-1:0] d;

        col_tab = '{9'd0, 9'd1, 9'd2, 9'd3, 9'd4, 9'd5, 9'd8, 9'd16,
                    9'd255, 9'd256, 9'd257, 9'd300, 9'd511};

        rst_n   = 1'b0;
        en      = 1'b0;
        col     = UW'(COLN);
        buf_in1 = '0;
        buf_in2 = '0;
        m_prev  = UW'(COLN);
        m_out   = '0;
        k       = 0;

        // Reset, including en low together with reset.
        drive(1'b0, 1'b0, 9'd8, 8'd0, 8'd0);
        drive(1'b0, 1'b1, 9'd8, 8'd55, 8'd66);

        // Counting stream, channel 2 offset by 100.
        for (int i = 1; i <= 30; i++) begin
            k = i;
            drive(1'b1, 1'b1, 9'd8, BW'(k), BW'(100 + k));
        end

        // Hold for three cycles with junk inputs, then resume.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 9'd8, BW'($urandom), BW'($urandom));
        end
        for (int i = 0; i < 15; i++) begin
            k++;
            drive(1'b1, 1'b1, 9'd8, BW'(k), BW'(100 + k));
        end

        // One-edge reset mid-stream.
        drive(1'b0, 1'b1, 9'd8, BW'(k), BW'(100 + k));
        for (int i = 0; i < 15; i++) begin
            k++;
            drive(1'b1, 1'b1, 9'd8, BW'(k), BW'(100 + k));
        end

        // Shorten the row 8 -> 4 mid-stream.
        for (int i = 0; i < 20; i++) begin
            k++;
            drive(1'b1, 1'b1, 9'd4, BW'(k), BW'(100 + k));
        end

        // Boundary lengths: 1, 0 (clamped to 1), 300 (clamped to 256).
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 9'd1, BW'($urandom), BW'($urandom));
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, 9'd0, BW'($urandom), BW'($urandom));
        for (int i = 0; i < 270; i++) begin
            k++;
            drive(1'b1, 1'b1, 9'd300, BW'(k), BW'(100 + k));
        end

        // Random mix of enable, occasional reset and col changes.
        cur_col = 9'd8;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) cur_col = col_tab[$urandom_range(0, 12)];
            r = ($urandom_range(0, 99) != 0);
            e = ($urandom_range(0, 3) != 0);
            d = BW'($urandom);
            drive(r, e, cur_col, d, BW'($urandom));
        end

        // Drain the scoreboard with a bounded wait.
        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain pending=%0d exp=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
